drive_sequencer: RTL



---
 rtl/drive_seq_pkg.sv | 15 +
 rtl/drive_sequencer_tweak_window.sv | 23 ++
 rtl/drive_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/drive_seq_pkg.sv
// Shared types and constants for the pad-driver output sequencer.
// Per-lane off values are single bits so they can be replicated to any word width.
package drive_seq_pkg;
   typedef enum logic [1:0] {OFF, DEAD, DRIVE} state_t;

   localparam logic P_OFF = 1'b1;
   localparam logic N_OFF = 1'b0;

   localparam int N_TWEAK          = 8;
   localparam int DEF_WIDTH        = 8;
   localparam int DEF_DEAD_CYCLES  = 2;
   localparam int DEF_DELAY_CYCLES = 4;
   localparam int DEF_TWEAK_CYCLES = 3;
   localparam int DEF_CNT_W        = 8;
endpackage

// File: rtl/drive_sequencer_tweak_window.sv
// One lane's tweak window: open while the on-time index k lies in
// [off, off+TWEAK_CYCLES) and the lane's sense matches the current phase.
module tweak_window #(
   parameter int CNT_W        = 8,
   parameter int DELAY_CYCLES = 4,
   parameter int TWEAK_CYCLES = 3
) (
   input  logic [CNT_W-1:0] k,
   input  logic             phase,
   input  logic             sense,
   input  logic             delay_sel,
   output logic             win
);
   // One extra bit so off+TWEAK_CYCLES cannot overflow
   logic [CNT_W:0] k_ext;
   logic [CNT_W:0] off;
   logic [CNT_W:0] lim;

   assign k_ext = {1'b0, k};
   assign off   = delay_sel ? (CNT_W+1)'(DELAY_CYCLES) : '0;
   assign lim   = off + (CNT_W+1)'(TWEAK_CYCLES);
   assign win   = (sense == phase) && (k_ext >= off) && (k_ext < lim);
endmodule

// File: rtl/drive_sequencer.sv
// Re-times drive and tweak words against pwm, inserting a break-before-make
// dead time on every pwm edge and emitting registered gate signals.
module drive_sequencer
   import drive_seq_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
   parameter int DELAY_CYCLES = DEF_DELAY_CYCLES,
   parameter int TWEAK_CYCLES = DEF_TWEAK_CYCLES,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm,
   input  logic [WIDTH-1:0] p_drive,
   input  logic [WIDTH-1:0] n_drive,
   input  logic [WIDTH-1:0] tweak_delay,
   input  logic [WIDTH-1:0] tweak_sense,
   input  logic [WIDTH-1:0] tweak_drive_0,
   input  logic [WIDTH-1:0] tweak_drive_1,
   input  logic [WIDTH-1:0] tweak_drive_2,
   input  logic [WIDTH-1:0] tweak_drive_3,
   input  logic [WIDTH-1:0] tweak_drive_4,
   input  logic [WIDTH-1:0] tweak_drive_5,
   input  logic [WIDTH-1:0] tweak_drive_6,
   input  logic [WIDTH-1:0] tweak_drive_7,
   output logic [WIDTH-1:0] gate_p,
   output logic [WIDTH-1:0] gate_n,
   output logic [WIDTH-1:0] tweak_gate_0,
   output logic [WIDTH-1:0] tweak_gate_1,
   output logic [WIDTH-1:0] tweak_gate_2,
   output logic [WIDTH-1:0] tweak_gate_3,
   output logic [WIDTH-1:0] tweak_gate_4,
   output logic [WIDTH-1:0] tweak_gate_5,
   output logic [WIDTH-1:0] tweak_gate_6,
   output logic [WIDTH-1:0] tweak_gate_7,
   output logic             in_dead
);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic             pwm_s1_q, pwm_s1_d, pwm_s2_q, pwm_s2_d, phase_q, phase_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, k_next;
   logic [WIDTH-1:0] p_drive_q, p_drive_d, n_drive_q, n_drive_d;
   logic [WIDTH-1:0] tweak_delay_q, tweak_delay_d, tweak_sense_q, tweak_sense_d;
   logic [WIDTH-1:0] tweak_drive_q [N_TWEAK];
   logic [WIDTH-1:0] tweak_drive_d [N_TWEAK];
   logic [WIDTH-1:0] gate_p_q, gate_p_d, gate_n_q, gate_n_d;
   logic [WIDTH-1:0] tweak_gate_q [N_TWEAK];
   logic [WIDTH-1:0] tweak_gate_d [N_TWEAK];
   logic             in_dead_q, in_dead_d;
   logic             edge_det, drive_en;
   logic [WIDTH-1:0] win;

   // Index of the output cycle being computed; kept apart from the main
   // next-state logic so the window instances sit outside any comb loop.
   always_comb begin
      edge_det = (pwm_s2_q != phase_q);
      drive_en = 1'b0;
      k_next   = '0;
      if (!edge_det) begin
         case (state_q)
            DEAD:    drive_en = (cnt_q == DEAD_LAST);
            DRIVE: begin
               drive_en = 1'b1;
               k_next   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
            default: drive_en = 1'b0;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_lane
         tweak_window #(
            .CNT_W       (CNT_W),
            .DELAY_CYCLES(DELAY_CYCLES),
            .TWEAK_CYCLES(TWEAK_CYCLES)
         ) u_win (
            .k        (k_next),
            .phase    (phase_q),
            .sense    (tweak_sense_q[gi]),
            .delay_sel(tweak_delay_q[gi]),
            .win      (win[gi])
         );
      end
   endgenerate

   always_comb begin
      pwm_s1_d         = pwm;
      pwm_s2_d         = pwm_s1_q;
      p_drive_d        = p_drive;
      n_drive_d        = n_drive;
      tweak_delay_d    = tweak_delay;
      tweak_sense_d    = tweak_sense;
      tweak_drive_d[0] = tweak_drive_0;
      tweak_drive_d[1] = tweak_drive_1;
      tweak_drive_d[2] = tweak_drive_2;
      tweak_drive_d[3] = tweak_drive_3;
      tweak_drive_d[4] = tweak_drive_4;
      tweak_drive_d[5] = tweak_drive_5;
      tweak_drive_d[6] = tweak_drive_6;
      tweak_drive_d[7] = tweak_drive_7;
      phase_d   = phase_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_dead_d = 1'b0;
      gate_p_d  = {WIDTH{P_OFF}};
      gate_n_d  = {WIDTH{N_OFF}};
      for (int t = 0; t < N_TWEAK; t++) tweak_gate_d[t] = '0;

      // A pwm edge restarts the dead time from any state
      if (edge_det) begin
         phase_d   = pwm_s2_q;
         state_d   = DEAD;
         cnt_d     = '0;
         in_dead_d = 1'b1;
      end else begin
         case (state_q)
            DEAD: begin
               if (drive_en) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d     = cnt_q + CNT_W'(1);
                  in_dead_d = 1'b1;
               end
            end
            DRIVE:   cnt_d = k_next;
            default: state_d = OFF;
         endcase
      end

      if (drive_en) begin
         gate_p_d = phase_q ? p_drive_q : {WIDTH{P_OFF}};
         gate_n_d = phase_q ? {WIDTH{N_OFF}} : n_drive_q;
         for (int t = 0; t < N_TWEAK; t++) tweak_gate_d[t] = tweak_drive_q[t] & win;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_s1_q      <= 1'b0;
         pwm_s2_q      <= 1'b0;
         phase_q       <= 1'b0;
         state_q       <= OFF;
         cnt_q         <= '0;
         p_drive_q     <= {WIDTH{P_OFF}};
         n_drive_q     <= {WIDTH{N_OFF}};
         tweak_delay_q <= '0;
         tweak_sense_q <= '0;
         gate_p_q      <= {WIDTH{P_OFF}};
         gate_n_q      <= {WIDTH{N_OFF}};
         in_dead_q     <= 1'b0;
         for (int t = 0; t < N_TWEAK; t++) begin
            tweak_drive_q[t] <= '0;
            tweak_gate_q[t]  <= '0;
         end
      end else begin
         pwm_s1_q      <= pwm_s1_d;
         pwm_s2_q      <= pwm_s2_d;
         phase_q       <= phase_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         p_drive_q     <= p_drive_d;
         n_drive_q     <= n_drive_d;
         tweak_delay_q <= tweak_delay_d;
         tweak_sense_q <= tweak_sense_d;
         gate_p_q      <= gate_p_d;
         gate_n_q      <= gate_n_d;
         in_dead_q     <= in_dead_d;
         for (int t = 0; t < N_TWEAK; t++) begin
            tweak_drive_q[t] <= tweak_drive_d[t];
            tweak_gate_q[t]  <= tweak_gate_d[t];
         end
      end
   end

   assign gate_p       = gate_p_q;
   assign gate_n       = gate_n_q;
   assign in_dead      = in_dead_q;
   assign tweak_gate_0 = tweak_gate_q[0];
   assign tweak_gate_1 = tweak_gate_q[1];
   assign tweak_gate_2 = tweak_gate_q[2];
   assign tweak_gate_3 = tweak_gate_q[3];
   assign tweak_gate_4 = tweak_gate_q[4];
   assign tweak_gate_5 = tweak_gate_q[5];
   assign tweak_gate_6 = tweak_gate_q[6];
   assign tweak_gate_7 = tweak_gate_q[7];
endmodule
